// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target with a fixed-latency response
// handshake, per-byte write enables and a sticky out-of-range error flag.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_reqValid,
  output logic        io_respValid,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic [1:0]  io_size,
  input  logic        io_wen,
  input  logic [3:0]  io_wmask,
  output logic        err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam bit          LAT_ZERO = (LATENCY == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic             wen_q;
  logic             in_range_q;
  logic             resp_q;
  logic             err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset_c;
  logic [31:0]      word_off_c;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;
  logic             accept_c;
  logic             rd_en_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic             unused_bits;

  // Address decode: unsigned wrap makes addresses below the base out of range
  always_comb begin
    offset_c   = io_addr - BASE_ADDR;
    word_off_c = {2'b00, offset_c[31:2]};
    in_range_c = (word_off_c < 32'(DEPTH_WORDS));
    idx_c      = IDX_W'(word_off_c);
    accept_c   = io_reqValid && (state == IDLE);
  end

  // Size is irrelevant to a word-wide target and the byte offset is ignored
  assign unused_bits = ^{io_size, offset_c[1:0]};

  // Request FSM: capture at acceptance, count down, one-cycle response
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      wen_q      <= 1'b0;
      in_range_q <= 1'b0;
      resp_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      if (accept_c && !in_range_c) begin
        err_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept_c && !LAT_ZERO) begin
            idx_q      <= idx_c;
            wen_q      <= io_wen;
            in_range_q <= in_range_c;
            cnt        <= CNT_LOAD;
            if (CNT_LOAD == '0) begin
              state  <= RESP;
              resp_q <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state  <= RESP;
            resp_q <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage: byte-lane writes committed at the end of the acceptance cycle
  always_ff @(posedge clock) begin
    if (accept_c && io_wen && in_range_c) begin
      for (int i = 0; i < 4; i++) begin
        if (io_wmask[i]) begin
          mem[idx_c][8*i +: 8] <= io_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read path: zero unless responding to an in-range read
  always_comb begin
    rd_en_c  = LAT_ZERO ? (accept_c && !io_wen && in_range_c)
                        : (resp_q && !wen_q && in_range_q);
    rd_idx_c = LAT_ZERO ? idx_c : idx_q;
    io_rdata = rd_en_c ? mem[rd_idx_c] : 32'h0;
  end

  // Zero-latency responses are combinational and suppressed in reset
  assign io_respValid = LAT_ZERO ? (accept_c && reset_n) : resp_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vectors plus hand sequences for mem_responder.
module tb_mem_responder;

  logic        clock;
  logic        reset_n;

  logic        io_reqValid, io_respValid, io_wen, err;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic [1:0]  io_size;
  logic [3:0]  io_wmask;

  logic        req0, resp0, wen0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  mask0;

  int errors = 0;
  int checks = 0;

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) dut (
    .clock(clock), .reset_n(reset_n), .io_reqValid(io_reqValid),
    .io_respValid(io_respValid), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_size(io_size), .io_wen(io_wen),
    .io_wmask(io_wmask), .err(err)
  );

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .io_reqValid(req0),
    .io_respValid(resp0), .io_addr(addr0), .io_wdata(wdata0),
    .io_rdata(rdata0), .io_size(2'b10), .io_wen(wen0),
    .io_wmask(mask0), .err(err0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; call right after a posedge.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                        input logic w, output logic [31:0] rd, output int pcyc,
                        output int npulse, output logic err1, output logic idle_bad);
    io_addr = a; io_wdata = wd; io_wmask = m; io_wen = w; io_reqValid = 1'b1;
    rd = 32'hFFFF_FFFF; pcyc = -1; npulse = 0; err1 = 1'b0; idle_bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (c == 1) err1 = err;
      if (io_respValid) begin
        npulse++;
        if (pcyc < 0) begin
          pcyc = c;
          rd = io_rdata;
        end
      end else if (io_rdata !== 32'h0) begin
        idle_bad = 1'b1;
      end
      @(posedge clock); #1;
      if (c == pcyc) io_reqValid = 1'b0;
    end
    io_reqValid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wen;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[12];

  initial begin
    logic [31:0] rd;
    int          pc, np, p1, p2;
    logic        e1, ib;

    tv[0]  = '{32'h8000_0010, 32'hA5A5_1234, 4'b1111, 1'b1, 32'h0};
    tv[1]  = '{32'h8000_0010, 32'h0,         4'b0000, 1'b0, 32'hA5A5_1234};
    tv[2]  = '{32'h8000_0010, 32'h0000_BB00, 4'b0010, 1'b1, 32'h0};
    tv[3]  = '{32'h8000_0010, 32'h0,         4'b0000, 1'b0, 32'hA5A5_BB34};
    tv[4]  = '{32'h8000_0010, 32'h1122_3344, 4'b0000, 1'b1, 32'h0};
    tv[5]  = '{32'h8000_0010, 32'h0,         4'b0000, 1'b0, 32'hA5A5_BB34};
    tv[6]  = '{32'h8000_0FFC, 32'h0102_0304, 4'b1111, 1'b1, 32'h0};
    tv[7]  = '{32'h8000_0FFC, 32'hDEAD_BEEF, 4'b1001, 1'b1, 32'h0};
    tv[8]  = '{32'h8000_0FFC, 32'h0,         4'b0000, 1'b0, 32'hDE02_03EF};
    tv[9]  = '{32'h8000_0014, 32'h0BAD_F00D, 4'b1111, 1'b1, 32'h0};
    tv[10] = '{32'h8000_0000, 32'h55AA_55AA, 4'b1111, 1'b1, 32'h0};
    tv[11] = '{32'h8000_0013, 32'h0,         4'b0000, 1'b0, 32'hA5A5_BB34};

    reset_n = 1'b0;
    io_reqValid = 1'b0; io_addr = '0; io_wdata = '0; io_size = 2'b10;
    io_wen = 1'b0; io_wmask = '0;
    req0 = 1'b0; addr0 = '0; wdata0 = '0; wen0 = 1'b0; mask0 = '0;

    #2;
    chk("reset_respValid", 32'(io_respValid), 32'h0);
    chk("reset_rdata", io_rdata, 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_respValid_lat0", 32'(resp0), 32'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Table-driven single transactions
    for (int i = 0; i < 12; i++) begin
      do_req(tv[i].addr, tv[i].wdata, tv[i].mask, tv[i].wen, rd, pc, np, e1, ib);
      chk($sformatf("vec%0d_latency", i), 32'(pc), 32'd2);
      chk($sformatf("vec%0d_pulses", i), 32'(np), 32'd1);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'h0);
      chk($sformatf("vec%0d_idle_rdata", i), 32'(ib), 32'h0);
    end

    // Back-to-back: request held through RESP with a new address set in WAIT
    io_addr = 32'h8000_0010; io_wen = 1'b0; io_reqValid = 1'b1;
    p1 = -1; p2 = -1; np = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (io_respValid) begin
        np++;
        if (p1 < 0) begin
          p1 = c;
          chk("b2b_rdata1", io_rdata, 32'hA5A5_BB34);
        end else if (p2 < 0) begin
          p2 = c;
          chk("b2b_rdata2", io_rdata, 32'h0BAD_F00D);
        end
      end
      @(posedge clock); #1;
      if (c == 0) io_addr = 32'h8000_0014;
      if (c == p2) io_reqValid = 1'b0;
    end
    io_reqValid = 1'b0;
    chk("b2b_first_cycle", 32'(p1), 32'd2);
    chk("b2b_second_cycle", 32'(p2), 32'd5);
    chk("b2b_pulses", 32'(np), 32'd2);

    // Request dropped during WAIT still completes
    io_addr = 32'h8000_0000; io_wen = 1'b0; io_reqValid = 1'b1;
    p1 = -1; np = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (io_respValid) begin
        np++;
        if (p1 < 0) begin
          p1 = c;
          chk("drop_rdata", io_rdata, 32'h55AA_55AA);
        end
      end
      @(posedge clock); #1;
      if (c == 0) io_reqValid = 1'b0;
    end
    chk("drop_cycle", 32'(p1), 32'd2);
    chk("drop_pulses", 32'(np), 32'd1);

    // Out-of-range accesses: wrap below base, and one past the end
    do_req(32'h7FFF_FFFC, 32'h0, 4'b0000, 1'b0, rd, pc, np, e1, ib);
    chk("oor_rd_rdata", rd, 32'h0);
    chk("oor_rd_latency", 32'(pc), 32'd2);
    chk("oor_rd_err_after_accept", 32'(e1), 32'h1);
    do_req(32'h8000_1000, 32'hDEAD_DEAD, 4'b1111, 1'b1, rd, pc, np, e1, ib);
    chk("oor_wr_latency", 32'(pc), 32'd2);
    chk("oor_wr_err", 32'(err), 32'h1);
    do_req(32'h8000_0000, 32'h0, 4'b0000, 1'b0, rd, pc, np, e1, ib);
    chk("oor_wr_dropped", rd, 32'h55AA_55AA);
    chk("err_sticky", 32'(err), 32'h1);

    // Reset during WAIT discards the response and keeps memory
    io_addr = 32'h8000_0010; io_wen = 1'b0; io_reqValid = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    reset_n = 1'b0; io_reqValid = 1'b0;
    #1;
    chk("rst_wait_respValid", 32'(io_respValid), 32'h0);
    chk("rst_wait_err", 32'(err), 32'h0);
    chk("rst_wait_rdata", io_rdata, 32'h0);
    np = 0;
    repeat (2) begin
      @(negedge clock);
      if (io_respValid) np++;
    end
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (io_respValid) np++;
    end
    chk("rst_no_pulse", 32'(np), 32'h0);
    chk("rst_err_clear", 32'(err), 32'h0);
    @(posedge clock); #1;
    do_req(32'h8000_0010, 32'h0, 4'b0000, 1'b0, rd, pc, np, e1, ib);
    chk("rst_mem_kept", rd, 32'hA5A5_BB34);
    chk("rst_idle_latency", 32'(pc), 32'd2);

    // Zero-latency instance: same-cycle responses
    addr0 = 32'h8000_0010; wdata0 = 32'hCAFE_BABE; mask0 = 4'b1111; wen0 = 1'b1; req0 = 1'b1;
    @(negedge clock);
    chk("lat0_wr_resp", 32'(resp0), 32'h1);
    chk("lat0_wr_rdata", rdata0, 32'h0);
    @(posedge clock); #1 wen0 = 1'b0;
    @(negedge clock);
    chk("lat0_rd_resp", 32'(resp0), 32'h1);
    chk("lat0_rd_rdata", rdata0, 32'hCAFE_BABE);
    chk("lat0_err", 32'(err0), 32'h0);
    @(posedge clock); #1 req0 = 1'b0;
    @(negedge clock);
    chk("lat0_idle_resp", 32'(resp0), 32'h0);
    chk("lat0_idle_rdata", rdata0, 32'h0);
    @(posedge clock); #1 addr0 = 32'h7FFF_FFFC; req0 = 1'b1;
    @(negedge clock);
    chk("lat0_oor_resp", 32'(resp0), 32'h1);
    chk("lat0_oor_rdata", rdata0, 32'h0);
    @(posedge clock); #1 req0 = 1'b0;
    @(negedge clock);
    chk("lat0_oor_err", 32'(err0), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
